approx_add_sched: RTL and testbench
===================================

# approx_add_sched

Two-requester scheduler and configurator for a shared 16-bit ripple-carry adder whose low K bit positions use the approximate OR-cell (sum = X|Y, carry-out forced 0) and whose upper 16−K positions are exact full adders. It arbitrates round-robin between two valid/ready requesters and registers one 17-bit result per accepted operation. The result carries a tag identifying the requester and is held under output backpressure. It sits between operand producers and the result consumer in the approximate-arithmetic datapath, so the adder can be shared and its approximation depth changed at run time.

## Interface
- WIDTH, 16, operand width; result is WIDTH+1 bits
- KW, 4, width of approximation-depth field; K ranges 0..WIDTH−1
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester operand valid
- req_ready  out  2  per-requester accept; at most one bit high per cycle
- req_a  in  2×WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  2×WIDTH  operand B, same packing
- cfg_we  in  1  write approximation depth
- cfg_k  in  KW  new depth K
- cur_k  out  KW  depth currently in effect
- out_valid  out  1  result register full
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH+1  registered sum
- out_tag  out  1  requester index of out_sum
- op_count  out  16  accepted operations since reset; wraps 0xFFFF→0

## Operation
- Adder, given K: for i<K, S[i]=A[i]|B[i], with no carry generated out of the approximate region. For i≥K, exact ripple with carry-in 0 at bit K. out_sum[WIDTH] is the final exact carry. K=0 is a fully exact adder.
- Slot free: `free = !out_valid || out_ready`.
- Arbitration: round-robin with a 1-bit pointer `prio`.
  - If both requesters are valid, grant `prio`; otherwise grant the single valid requester.
  - `req_ready[g] = free && req_valid[g]`. `req_ready` is 0 for any requester that is not valid.
  - On acceptance: `prio <= ~g`. The pointer is unchanged when nothing is accepted.
- Acceptance (`free && |req_valid`): in the same edge, load out_sum and out_tag, set out_valid=1, and increment op_count.
- Drain: when `out_valid && out_ready` and no new acceptance, clear out_valid. With a simultaneous drain and accept, out_valid stays 1 and the new result replaces the old one (full throughput).
- Config: on `cfg_we`, `cur_k <= cfg_k` at that edge. An acceptance in the same cycle uses the old cur_k; the new K applies from the next acceptance. A result already held in the output register is never recomputed.
- State machine, 2 states on out_valid: EMPTY→FULL on accept; FULL→EMPTY on drain without accept; FULL→FULL on accept-with-drain or on stall.
- Reset values: out_valid=0, out_sum=0, out_tag=0, prio=0, cur_k=WIDTH−1 (15), op_count=0, req_ready=0 during the reset cycle.
- Reset mid-operation: a held result is discarded and no handshake completes in the reset cycle.

## Timing
- Latency: 1 cycle from accept edge to out_valid.
- Throughput: 1 operation per cycle while out_ready=1.
- Stall: out_valid, out_sum and out_tag remain stable while `out_valid && !out_ready`.
- `req_ready` is combinational from out_valid, out_ready, req_valid and prio. There is no combinational path from any data input to req_ready.
- Adder is a single-cycle combinational path (ripple, WIDTH cells) from the operand mux to the output register.

## Structure
- Package `approx_add_pkg`: WIDTH, KW, reset depth constant K_RST=WIDTH−1, and tag type.
- Sub-module `approx_rc_adder_k`: combinational WIDTH-bit adder with a K input, built from per-bit mux between the approximate OR-cell and an exact full adder, with carry into bit i gated to 0 for i≤K. Everything else lives in the top block: arbiter, config register, output register and counter.

## Test plan
- K=0, requester 0 sends A=0xFFFF, B=0x0001 → out_sum=0x10000, tag=0, one cycle later.
- Default K=15 after reset, A=0xFFFF, B=0x0001 → out_sum=0x0FFFF. With A=0x0003, B=0x0001 → 0x00003.
- Both requesters valid continuously with out_ready=1 → grants alternate 0,1,0,1, one result per cycle, and op_count increases by 1 per cycle.
- out_ready=0 for 3 cycles with result held → out_sum and out_tag stable, req_ready=0. On out_ready=1, drain and new accept occur in the same cycle with no bubble.
- cfg_we with cfg_k=0 in the same cycle as an accept of 0x0003+0x0001 (cur_k=15) → that result is 0x00003; the next identical op yields 0x00004.
- Assert rst while out_valid=1 → next cycle out_valid=0, cur_k=15, op_count=0, and prio favours requester 0.

Source files
------------

// File: rtl/approx_add_pkg.sv
// approx_add_pkg: shared widths, reset depth and types for the approximate adder scheduler.
package approx_add_pkg;
    localparam int WIDTH = 16;
    localparam int KW = 4;
    localparam int CW = 16;
    localparam logic [KW-1:0] K_RST = KW'(WIDTH - 1);
    typedef logic tag_t;
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/approx_add_sched_if.sv
// approx_add_sched_if: requester, config and result signals of the shared adder scheduler.
interface approx_add_sched_if import approx_add_pkg::*; ();
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic cfg_we;
    logic [KW-1:0] cfg_k;
    logic [KW-1:0] cur_k;
    logic out_valid;
    logic out_ready;
    logic [WIDTH:0] out_sum;
    tag_t out_tag;
    logic [CW-1:0] op_count;
    modport master (
        output req_valid, req_a, req_b, cfg_we, cfg_k, out_ready,
        input req_ready, cur_k, out_valid, out_sum, out_tag, op_count
    );
    modport slave (
        input req_valid, req_a, req_b, cfg_we, cfg_k, out_ready,
        output req_ready, cur_k, out_valid, out_sum, out_tag, op_count
    );
endinterface

// File: rtl/approx_rc_adder_k.sv
// approx_rc_adder_k: ripple adder with OR-cells below bit k_i and exact full adders from bit k_i up.
module approx_rc_adder_k import approx_add_pkg::*; (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH:0]   sum_o
);
    logic cy;
    logic ci;
    always_comb begin
        cy = 1'b0;
        ci = 1'b0;
        sum_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // the exact region starts fresh: no carry leaks out of the OR-cells
            ci = (i <= int'(k_i)) ? 1'b0 : cy;
            sum_o[i] = (i < int'(k_i)) ? (a_i[i] | b_i[i]) : (a_i[i] ^ b_i[i] ^ ci);
            cy = (i < int'(k_i)) ? 1'b0 : ((a_i[i] & b_i[i]) | (ci & (a_i[i] ^ b_i[i])));
        end
        sum_o[WIDTH] = cy;
    end
endmodule

// File: rtl/approx_add_sched.sv
// approx_add_sched: round-robin sharing of one approximate adder between two requesters,
// with run-time depth config, a tagged result register and an accepted-op counter.
module approx_add_sched import approx_add_pkg::*; (
    input logic clk,
    input logic rst,
    approx_add_sched_if.slave bus
);
    state_t state_q, state_d;
    logic [WIDTH:0] sum_q, sum_d;
    tag_t tag_q, tag_d;
    logic prio_q, prio_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic free;
    logic acc;
    tag_t g;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0] s;
    assign free = (state_q == EMPTY) || bus.out_ready;
    assign g = (&bus.req_valid) ? prio_q : bus.req_valid[1];
    assign acc = !rst && free && |bus.req_valid;
    assign bus.req_ready = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
    assign a = g ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
    assign b = g ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
    approx_rc_adder_k u_add (
        .a_i(a),
        .b_i(b),
        .k_i(k_q),
        .sum_o(s)
    );
    always_comb begin
        state_d = acc ? FULL : (bus.out_ready ? EMPTY : state_q);
        sum_d = acc ? s : sum_q;
        tag_d = acc ? g : tag_q;
        prio_d = acc ? ~g : prio_q;
        cnt_d = cnt_q + CW'(acc);
        k_d = bus.cfg_we ? bus.cfg_k : k_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            sum_q <= '0;
            tag_q <= 1'b0;
            prio_q <= 1'b0;
            k_q <= K_RST;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q <= sum_d;
            tag_q <= tag_d;
            prio_q <= prio_d;
            k_q <= k_d;
            cnt_q <= cnt_d;
        end
    end
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_sum = sum_q;
    assign bus.out_tag = tag_q;
    assign bus.cur_k = k_q;
    assign bus.op_count = cnt_q;
endmodule

// File: tb/tb_approx_add_sched.sv
// tb_approx_add_sched: scoreboard bench for approx_add_sched plus directed scenario tasks.
module tb_approx_add_sched;
    import approx_add_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    approx_add_sched_if bus ();
    approx_add_sched dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] k);
        logic [16:0] hi;
        logic [15:0] m;
        m = 16'((17'h1 << k) - 17'h1);
        hi = (17'(a) >> k) + (17'(b) >> k);
        return (hi << k) | 17'((a | b) & m);
    endfunction
    logic m_valid = 1'b0;
    logic m_prio = 1'b0;
    logic [3:0] m_k = 4'hF;
    logic [15:0] m_cnt = 16'h0;
    logic [17:0] sb[$];
    logic e_free, e_acc, e_g;
    logic [1:0] e_rdy;
    logic [15:0] e_a, e_b;
    assign e_free = !m_valid || bus.out_ready;
    assign e_g = (&bus.req_valid) ? m_prio : bus.req_valid[1];
    assign e_acc = e_free && |bus.req_valid;
    assign e_rdy = e_acc ? (e_g ? 2'b10 : 2'b01) : 2'b00;
    assign e_a = e_g ? bus.req_a[31:16] : bus.req_a[15:0];
    assign e_b = e_g ? bus.req_b[31:16] : bus.req_b[15:0];
    always @(negedge clk) begin
        if (rst) begin
            n_cmp++;
            if (bus.req_ready !== 2'b00) begin
                n_err++;
                $display("FAIL sb_rst_ready: got %b want 00", bus.req_ready);
            end
            m_valid <= 1'b0;
            m_prio <= 1'b0;
            m_k <= 4'hF;
            m_cnt <= 16'h0;
            sb.delete();
        end else begin
            n_cmp++;
            if (bus.out_valid !== m_valid || bus.cur_k !== m_k || bus.op_count !== m_cnt) begin
                n_err++;
                $display("FAIL sb_state: got v=%b k=%h cnt=%h want v=%b k=%h cnt=%h",
                         bus.out_valid, bus.cur_k, bus.op_count, m_valid, m_k, m_cnt);
            end
            n_cmp++;
            if (bus.req_ready !== e_rdy) begin
                n_err++;
                $display("FAIL sb_ready: got %b want %b", bus.req_ready, e_rdy);
            end
            if (m_valid && sb.size() > 0) begin
                n_cmp++;
                if ({bus.out_tag, bus.out_sum} !== sb[0]) begin
                    n_err++;
                    $display("FAIL sb_result: got tag=%b sum=%h want tag=%b sum=%h",
                             bus.out_tag, bus.out_sum, sb[0][17], sb[0][16:0]);
                end
            end
            if (m_valid && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
            if (e_acc) begin
                sb.push_back({e_g, model(e_a, e_b, m_k)});
                m_prio <= ~e_g;
                m_cnt <= m_cnt + 16'h1;
            end
            m_valid <= e_acc || (m_valid && !bus.out_ready);
            if (bus.cfg_we) m_k <= bus.cfg_k;
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic op(input tag_t r, input logic [15:0] a, input logic [15:0] b,
                      output logic [16:0] s, output tag_t t);
        bus.req_valid = r ? 2'b10 : 2'b01;
        if (r) begin
            bus.req_a[31:16] = a;
            bus.req_b[31:16] = b;
        end else begin
            bus.req_a[15:0] = a;
            bus.req_b[15:0] = b;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        s = bus.out_sum;
        t = bus.out_tag;
        tick();
    endtask
    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_k = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.cur_k, bus.op_count, bus.out_sum, bus.out_tag} !== {1'b0, 4'hF, 16'h0, 17'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got v=%b k=%h cnt=%h sum=%h tag=%b want v=0 k=f cnt=0000 sum=00000 tag=0",
                     bus.out_valid, bus.cur_k, bus.op_count, bus.out_sum, bus.out_tag);
        end
        tick();
    endtask
    task automatic test_default_k;
        logic [16:0] s;
        tag_t t;
        bus.out_ready = 1'b1;
        op(1'b0, 16'hFFFF, 16'h0001, s, t);
        n_cmp++;
        if (s !== 17'h0FFFF || t !== 1'b0) begin
            n_err++;
            $display("FAIL k15_ffff: got sum=%h tag=%b want sum=0ffff tag=0", s, t);
        end
        op(1'b1, 16'h0003, 16'h0001, s, t);
        n_cmp++;
        if (s !== 17'h00003 || t !== 1'b1) begin
            n_err++;
            $display("FAIL k15_small: got sum=%h tag=%b want sum=00003 tag=1", s, t);
        end
    endtask
    task automatic test_cfg_same_cycle;
        logic [16:0] s;
        tag_t t;
        bus.cfg_we = 1'b1;
        bus.cfg_k = 4'h0;
        op(1'b0, 16'h0003, 16'h0001, s, t);
        bus.cfg_we = 1'b0;
        n_cmp++;
        if (s !== 17'h00003) begin
            n_err++;
            $display("FAIL cfg_old_k: got sum=%h want sum=00003", s);
        end
        op(1'b0, 16'h0003, 16'h0001, s, t);
        n_cmp++;
        if (s !== 17'h00004 || bus.cur_k !== 4'h0) begin
            n_err++;
            $display("FAIL cfg_new_k: got sum=%h k=%h want sum=00004 k=0", s, bus.cur_k);
        end
    endtask
    task automatic test_exact_k0;
        logic [16:0] s;
        tag_t t;
        op(1'b0, 16'hFFFF, 16'h0001, s, t);
        n_cmp++;
        if (s !== 17'h10000 || t !== 1'b0) begin
            n_err++;
            $display("FAIL k0_carry: got sum=%h tag=%b want sum=10000 tag=0", s, t);
        end
    endtask
    task automatic test_mid_k;
        logic [16:0] s;
        tag_t t;
        bus.cfg_we = 1'b1;
        bus.cfg_k = 4'h8;
        tick();
        bus.cfg_we = 1'b0;
        op(1'b1, 16'h00FF, 16'h0001, s, t);
        n_cmp++;
        if (s !== 17'h000FF || t !== 1'b1) begin
            n_err++;
            $display("FAIL k8_low: got sum=%h tag=%b want sum=000ff tag=1", s, t);
        end
        op(1'b0, 16'h01FF, 16'h0180, s, t);
        n_cmp++;
        if (s !== 17'h002FF) begin
            n_err++;
            $display("FAIL k8_high: got sum=%h want sum=002ff", s);
        end
    endtask
    task automatic test_back_to_back;
        logic [1:0] prev;
        logic [1:0] cur;
        prev = 2'b00;
        bus.out_ready = 1'b1;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            bus.req_a = {16'($urandom), 16'($urandom)};
            bus.req_b = {16'($urandom), 16'($urandom)};
            @(negedge clk);
            cur = bus.req_ready;
            n_cmp++;
            if ((cur !== 2'b01 && cur !== 2'b10) || (i > 0 && cur !== ~prev)) begin
                n_err++;
                $display("FAIL b2b_alternate: cycle %0d got %b want %b", i, cur, ~prev);
            end
            if (i > 0) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_valid: cycle %0d got %b want 1", i, bus.out_valid);
                end
            end
            prev = cur;
            tick();
        end
        bus.req_valid = 2'b00;
        tick();
    endtask
    task automatic test_stall;
        logic [16:0] held;
        bus.out_ready = 1'b1;
        bus.req_valid = 2'b01;
        bus.req_a[15:0] = 16'h1234;
        bus.req_b[15:0] = 16'h0F0F;
        held = model(16'h1234, 16'h0F0F, m_k);
        tick();
        bus.out_ready = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_a = {16'h4000, 16'h5555};
        bus.req_b = {16'h4000, 16'h2222};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.req_ready !== 2'b00 || bus.out_valid !== 1'b1 || bus.out_sum !== held || bus.out_tag !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: cycle %0d got rdy=%b v=%b sum=%h tag=%b want rdy=00 v=1 sum=%h tag=0",
                         i, bus.req_ready, bus.out_valid, bus.out_sum, bus.out_tag, held);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL stall_release: got %b want 10", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 1'b1 || bus.out_sum !== model(16'h4000, 16'h4000, m_k)) begin
            n_err++;
            $display("FAIL stall_no_bubble: got v=%b tag=%b sum=%h want v=1 tag=1 sum=%h",
                     bus.out_valid, bus.out_tag, bus.out_sum, model(16'h4000, 16'h4000, m_k));
        end
        tick();
    endtask
    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        bus.req_valid = 2'b01;
        tick();
        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 2'b00 || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_cycle: got rdy=%b v=%b want rdy=00 v=1", bus.req_ready, bus.out_valid);
        end
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.cur_k, bus.op_count, bus.req_ready} !== {1'b0, 4'hF, 16'h0, 2'b01}) begin
            n_err++;
            $display("FAIL rst_mid_after: got v=%b k=%h cnt=%h rdy=%b want v=0 k=f cnt=0000 rdy=01",
                     bus.out_valid, bus.cur_k, bus.op_count, bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b1;
        repeat (2) tick();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_default_k();
        test_cfg_same_cycle();
        test_exact_k0();
        test_mid_k();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
